// File: rtl/target_counter_8_bits_if.sv
// Control/target/status bundle between the target counter and its environment,
// including the combinational comparator feedback (cmp_*).
interface target_counter_8_bits_if;
  logic       load;
  logic [7:0] alvo;
  logic       start;
  logic       parar;
  logic       cmp_e;
  logic       cmp_plus;
  logic       cmp_less;
  logic [7:0] contagem;
  logic [7:0] alvo_q;
  logic       busy;
  logic       done;
  logic       erro;
  logic [8:0] passos;

  modport master (
    output load, alvo, start, parar, cmp_e, cmp_plus, cmp_less,
    input  contagem, alvo_q, busy, done, erro, passos
  );

  modport slave (
    input  load, alvo, start, parar, cmp_e, cmp_plus, cmp_less,
    output contagem, alvo_q, busy, done, erro, passos
  );
endinterface

// File: rtl/target_counter_8_bits.sv
// Up/down counter that walks contagem toward a latched target one step per clock,
// steered by an external magnitude comparator; flags inconsistent compares and timeouts.
module target_counter_8_bits #(
  parameter int TIMEOUT = 256
) (
  input logic                    clk,
  input logic                    rst_n,
  target_counter_8_bits_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERRO} state_t;

  localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] contagem_q, contagem_d;
  logic [7:0] alvo_q, alvo_d;
  logic [8:0] passos_q, passos_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       erro_q, erro_d;
  logic       cmp_onehot;

  function automatic logic [8:0] passos_inc(input logic [8:0] p);
    return (p == 9'h1FF) ? p : p + 9'd1;
  endfunction

  assign cmp_onehot = ({bus.cmp_e, bus.cmp_plus, bus.cmp_less} == 3'b100) ||
                      ({bus.cmp_e, bus.cmp_plus, bus.cmp_less} == 3'b010) ||
                      ({bus.cmp_e, bus.cmp_plus, bus.cmp_less} == 3'b001);

  always_comb begin
    state_d    = state_q;
    contagem_d = contagem_q;
    alvo_d     = alvo_q;
    passos_d   = passos_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    erro_d     = erro_q;

    unique case (state_q)
      IDLE: begin
        if (bus.load) alvo_d = bus.alvo;
        if (bus.start) begin
          state_d  = RUN;
          passos_d = 9'd0;
          busy_d   = 1'b1;
        end
      end

      RUN: begin
        if (bus.parar) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (!cmp_onehot || ({1'b0, passos_q} == TIMEOUT_W)) begin
          state_d = ERRO;
          erro_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (bus.cmp_e) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (bus.cmp_less) begin
          // Refuse to wrap: a "less" at the top of the range means the loop is broken.
          if (contagem_q == 8'hFF) begin
            state_d = ERRO;
            erro_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            contagem_d = contagem_q + 8'd1;
            passos_d   = passos_inc(passos_q);
          end
        end else begin
          if (contagem_q == 8'h00) begin
            state_d = ERRO;
            erro_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            contagem_d = contagem_q - 8'd1;
            passos_d   = passos_inc(passos_q);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        if (bus.load) alvo_d = bus.alvo;
      end

      ERRO: begin
        if (bus.load) begin
          state_d = IDLE;
          erro_d  = 1'b0;
          alvo_d  = bus.alvo;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      contagem_q <= 8'd0;
      alvo_q     <= 8'd0;
      passos_q   <= 9'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      contagem_q <= contagem_d;
      alvo_q     <= alvo_d;
      passos_q   <= passos_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      erro_q     <= erro_d;
    end
  end

  assign bus.contagem = contagem_q;
  assign bus.alvo_q   = alvo_q;
  assign bus.passos   = passos_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.erro     = erro_q;

endmodule

// File: tb/tb_target_counter_8_bits.sv
// Bench for target_counter_8_bits: closes the loop with an ideal comparator
// (optionally overridden to inject bad compares) and checks against a distance model.
module tb_target_counter_8_bits;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] force_mode = 2'd0;  // 0 real compare, 1 plus+less, 2 less only, 3 plus only
  int tests = 0;
  int fails = 0;
  int cur = 0;

  always #5 clk = ~clk;

  target_counter_8_bits_if bus ();

  assign bus.cmp_e    = (force_mode == 2'd0) && (bus.contagem == bus.alvo_q);
  assign bus.cmp_plus = (force_mode == 2'd0) ? (bus.contagem > bus.alvo_q)
                                             : (force_mode == 2'd1 || force_mode == 2'd3);
  assign bus.cmp_less = (force_mode == 2'd0) ? (bus.contagem < bus.alvo_q)
                                             : (force_mode == 2'd1 || force_mode == 2'd2);

  target_counter_8_bits #(.TIMEOUT(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".contagem"}, int'(bus.contagem), 0);
    chk({tag, ".alvo_q"},   int'(bus.alvo_q),   0);
    chk({tag, ".passos"},   int'(bus.passos),   0);
    chk({tag, ".busy"},     int'(bus.busy),     0);
    chk({tag, ".done"},     int'(bus.done),     0);
    chk({tag, ".erro"},     int'(bus.erro),     0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    cur = 0;
  endtask

  // Walk from cur to target; model: after k edges contagem = cur +/- min(k, d).
  task automatic run_to(input int target, input bit together);
    int d;
    int dir;
    if (!together) begin
      bus.load = 1'b1; bus.alvo = 8'(target);
      tick();
      bus.load = 1'b0;
    end
    bus.load = 1'b1; bus.alvo = 8'(target); bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    chk("run.busy_e0", int'(bus.busy), 1);
    chk("run.alvo_q", int'(bus.alvo_q), target);
    d   = (target > cur) ? target - cur : cur - target;
    dir = (target > cur) ? 1 : -1;
    for (int k = 1; k <= d; k++) begin
      tick();
      chk("run.contagem", int'(bus.contagem), cur + dir * k);
      chk("run.passos", int'(bus.passos), k);
      chk("run.busy", int'(bus.busy), 1);
      chk("run.done_early", int'(bus.done), 0);
    end
    tick();
    chk("run.done", int'(bus.done), 1);
    chk("run.passos_final", int'(bus.passos), d);
    chk("run.contagem_final", int'(bus.contagem), target);
    chk("run.busy_after", int'(bus.busy), 0);
    chk("run.erro", int'(bus.erro), 0);
    tick();
    chk("run.done_pulse", int'(bus.done), 0);
    cur = target;
  endtask

  initial begin
    bus.load = 1'b0; bus.alvo = 8'd0; bus.start = 1'b0; bus.parar = 1'b0;
    #2;
    chk_reset_outputs("reset_async");
    do_reset();
    chk_reset_outputs("reset");

    // Basic up-count, then a long down-count with load+start together, then d=0.
    run_to(5, 1'b0);
    run_to(200, 1'b1);
    run_to(3, 1'b1);
    run_to(3, 1'b0);

    // Inconsistent comparator mid-run.
    bus.load = 1'b1; bus.alvo = 8'd50; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    tick(); tick();
    chk("bad.contagem_pre", int'(bus.contagem), 5);
    force_mode = 2'd1;
    tick();
    chk("bad.erro", int'(bus.erro), 1);
    chk("bad.busy", int'(bus.busy), 0);
    chk("bad.contagem", int'(bus.contagem), 5);
    force_mode = 2'd0;
    bus.start = 1'b1;
    tick(); tick();
    bus.start = 1'b0;
    chk("bad.start_ignored_erro", int'(bus.erro), 1);
    chk("bad.start_ignored_busy", int'(bus.busy), 0);
    chk("bad.start_ignored_cnt", int'(bus.contagem), 5);
    bus.load = 1'b1; bus.alvo = 8'd77;
    tick();
    bus.load = 1'b0;
    chk("bad.erro_cleared", int'(bus.erro), 0);
    chk("bad.alvo_latched", int'(bus.alvo_q), 77);
    chk("bad.contagem_held", int'(bus.contagem), 5);
    cur = 5;

    // Abort at step 10 of 0->100, then resume.
    do_reset();
    bus.load = 1'b1; bus.alvo = 8'd100; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("parar.contagem_pre", int'(bus.contagem), 10);
    bus.parar = 1'b1;
    tick();
    bus.parar = 1'b0;
    chk("parar.contagem", int'(bus.contagem), 10);
    chk("parar.passos", int'(bus.passos), 10);
    chk("parar.busy", int'(bus.busy), 0);
    chk("parar.done", int'(bus.done), 0);
    tick();
    chk("parar.idle_cnt", int'(bus.contagem), 10);
    chk("parar.no_done", int'(bus.done), 0);
    cur = 10;
    run_to(100, 1'b0);

    // Randomized targets.
    for (int i = 0; i < 8; i++) begin
      run_to(int'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
    end

    // No wrap at the top and bottom of the range.
    run_to(255, 1'b1);
    force_mode = 2'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("wrap_hi.erro", int'(bus.erro), 1);
    chk("wrap_hi.contagem", int'(bus.contagem), 255);
    force_mode = 2'd0;
    bus.load = 1'b1; bus.alvo = 8'd0;
    tick();
    bus.load = 1'b0;
    chk("wrap_hi.cleared", int'(bus.erro), 0);
    run_to(0, 1'b1);
    force_mode = 2'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("wrap_lo.erro", int'(bus.erro), 1);
    chk("wrap_lo.contagem", int'(bus.contagem), 0);
    force_mode = 2'd0;
    bus.load = 1'b1; bus.alvo = 8'd0;
    tick();
    bus.load = 1'b0;

    // Asynchronous reset in the middle of a run, away from the clock edge.
    bus.load = 1'b1; bus.alvo = 8'd250; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    tick(); tick(); tick();
    chk("midrst.busy_pre", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst.stays_idle", int'(bus.busy), 0);
    chk("midrst.no_done", int'(bus.done), 0);
    chk("midrst.contagem", int'(bus.contagem), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
